// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: format selects and base opcodes.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_RSVD  = 3'b110;
    localparam logic [2:0] IMM_AUTO  = 3'b111;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side handshake bundle: instruction in, buffered immediate out.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
) ();
    logic            inValid;
    logic            inReady;
    logic [31:0]     instr;
    logic [2:0]      immSel;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] immOut;
    logic [2:0]      immFmt;
    logic            immErr;

    modport master (
        output inValid, instr, immSel, outReady,
        input  inReady, outValid, immOut, immFmt, immErr
    );

    modport slave (
        input  inValid, instr, immSel, outReady,
        output inReady, outValid, immOut, immFmt, immErr
    );
endinterface

// File: rtl/imm_decode_comb.sv
// Extracts and sign-extends the immediate for the selected (or opcode-derived) format.
// Latency: purely combinational.
// Backpressure: none; caller registers the result.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit AUTO_EN = 1'b1
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immSel,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            err
);

    logic [2:0]         w_fmt;
    logic signed [31:0] w_imm32;
    logic [5:0]         w_shamt;

    always_comb begin
        w_fmt = immSel;
        if (immSel == IMM_AUTO) begin
            if (AUTO_EN) begin
                case (instr[6:0])
                    OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: w_fmt = IMM_I;
                    OP_STORE:                            w_fmt = IMM_S;
                    OP_BRANCH:                           w_fmt = IMM_B;
                    OP_LUI, OP_AUIPC:                    w_fmt = IMM_U;
                    OP_JAL:                              w_fmt = IMM_J;
                    default:                             w_fmt = IMM_RSVD;
                endcase
            end else begin
                w_fmt = IMM_RSVD;
            end
        end

        w_shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
        w_imm32 = '0;
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   w_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase

        // shamt is the only zero-extended field; everything else widens from bit 31
        imm = (w_fmt == IMM_SHAMT) ? XLEN'(w_shamt) : XLEN'(w_imm32);
        fmt = w_fmt;
        err = (w_fmt == IMM_RSVD);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a DEPTH-entry FIFO output buffer.
// Latency: one cycle from accept to outValid; no in-to-out combinational path.
// Backpressure: inReady = !full from registered count; a pop never frees a slot in the same cycle.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 2,
    parameter bit AUTO_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_imm [DEPTH];
    logic [2:0]      r_fmt [DEPTH];
    logic            r_err [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_last_imm;
    logic [2:0]      r_last_fmt;
    logic            r_last_err;

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_err;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    imm_decode_comb #(
        .XLEN    (XLEN),
        .AUTO_EN (AUTO_EN)
    ) u_dec (
        .instr  (bus.instr),
        .immSel (bus.immSel),
        .imm    (w_imm),
        .fmt    (w_fmt),
        .err    (w_err)
    );

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.inValid && !w_full && !flush;
    assign w_pop   = !w_empty && bus.outReady && !flush;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_imm[i] <= '0;
                r_fmt[i] <= IMM_I;
                r_err[i] <= 1'b0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last_imm <= '0;
            r_last_fmt <= IMM_I;
            r_last_err <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_imm[r_tail] <= w_imm;
                r_fmt[r_tail] <= w_fmt;
                r_err[r_tail] <= w_err;
                r_tail        <= ptr_next(r_tail);
            end
            // keep a copy of what leaves so an empty buffer still shows the last delivered entry
            if (w_pop) begin
                r_last_imm <= r_imm[r_head];
                r_last_fmt <= r_fmt[r_head];
                r_last_err <= r_err[r_head];
                r_head     <= ptr_next(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.inReady  = !w_full;
    assign bus.outValid = !w_empty;
    assign bus.immOut   = w_empty ? r_last_imm : r_imm[r_head];
    assign bus.immFmt   = w_empty ? r_last_fmt : r_fmt[r_head];
    assign bus.immErr   = w_empty ? r_last_err : r_err[r_head];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: a 32-bit/DEPTH=2 instance and a 64-bit/DEPTH=1 instance on shared clock/reset.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk;
    logic rstN;
    logic flush;
    int   n_vec;
    int   n_err;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_EN(1'b1)) u_dut (
        .clk   (clk),
        .rstN  (rstN),
        .flush (flush),
        .bus   (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(1), .AUTO_EN(1'b1)) u_dut64 (
        .clk   (clk),
        .rstN  (rstN),
        .flush (flush),
        .bus   (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [2:0]  sel;
        logic [31:0] i32;
        logic [63:0] i64;
        logic [2:0]  fmt;
        logic        err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV] = '{
        '{32'hFFF00093, IMM_I,     32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, IMM_I,     1'b0},
        '{32'hFE112E23, IMM_AUTO,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, IMM_S,     1'b0},
        '{32'hFE000CE3, IMM_AUTO,  32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, IMM_B,     1'b0},
        '{32'h123450B7, IMM_AUTO,  32'h12345000, 64'h00000000_12345000, IMM_U,     1'b0},
        '{32'h12345678, IMM_RSVD,  32'h00000000, 64'h00000000_00000000, IMM_RSVD,  1'b1},
        '{32'h0000007F, IMM_AUTO,  32'h00000000, 64'h00000000_00000000, IMM_RSVD,  1'b1},
        '{32'h00500093, IMM_I,     32'h00000005, 64'h00000000_00000005, IMM_I,     1'b0},
        '{32'hFFDFF06F, IMM_J,     32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, IMM_J,     1'b0},
        '{32'hFFDFF06F, IMM_AUTO,  32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, IMM_J,     1'b0},
        '{32'h80000037, IMM_U,     32'h80000000, 64'hFFFFFFFF_80000000, IMM_U,     1'b0},
        '{32'h03F01013, IMM_SHAMT, 32'h0000001F, 64'h00000000_0000003F, IMM_SHAMT, 1'b0},
        '{32'h00812083, IMM_AUTO,  32'h00000008, 64'h00000000_00000008, IMM_I,     1'b0},
        '{32'hFFFFF097, IMM_AUTO,  32'hFFFFF000, 64'hFFFFFFFF_FFFFF000, IMM_U,     1'b0},
        '{32'hFE112E23, IMM_S,     32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, IMM_S,     1'b0}
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] ins, input logic [2:0] sel, input logic rdy);
        bus32.inValid  = v;
        bus32.instr    = ins;
        bus32.immSel   = sel;
        bus32.outReady = rdy;
    endtask

    task automatic drv64(input logic v, input logic [31:0] ins, input logic [2:0] sel, input logic rdy);
        bus64.inValid  = v;
        bus64.instr    = ins;
        bus64.immSel   = sel;
        bus64.outReady = rdy;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] imm, input logic [2:0] fmt, input logic err);
        chk({tag, "_vld"}, 64'(bus32.outValid), 64'd1);
        chk({tag, "_imm"}, 64'(bus32.immOut),   64'(imm));
        chk({tag, "_fmt"}, 64'(bus32.immFmt),   64'(fmt));
        chk({tag, "_err"}, 64'(bus32.immErr),   64'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rstN  = 1'b0;
        flush = 1'b0;
        drv(1'b0, 32'h0, IMM_I, 1'b0);
        drv64(1'b0, 32'h0, IMM_I, 1'b0);

        #2;
        chk("rst_vld",   64'(bus32.outValid), 64'd0);
        chk("rst_rdy",   64'(bus32.inReady),  64'd1);
        chk("rst_imm",   64'(bus32.immOut),   64'd0);
        chk("rst_fmt",   64'(bus32.immFmt),   64'd0);
        chk("rst_err",   64'(bus32.immErr),   64'd0);
        chk("rst64_rdy", 64'(bus64.inReady),  64'd1);
        chk("rst64_imm", bus64.immOut,        64'd0);
        tick();
        tick();
        rstN = 1'b1;
        tick();

        // Back-to-back stream with the consumer always ready: each entry shows one cycle after accept.
        for (int i = 0; i < NV; i++) begin
            drv(1'b1, vecs[i].ins, vecs[i].sel, 1'b1);
            tick();
            chk_out($sformatf("v%0d", i), vecs[i].i32, vecs[i].fmt, vecs[i].err);
        end
        drv(1'b0, 32'h0, IMM_I, 1'b1);
        tick();
        chk("drain_vld",  64'(bus32.outValid), 64'd0);
        chk("hold_imm",   64'(bus32.immOut),   64'(vecs[NV-1].i32));
        chk("hold_fmt",   64'(bus32.immFmt),   64'(vecs[NV-1].fmt));

        // Backpressure: three pushes into a 2-deep buffer with the consumer stalled.
        drv(1'b1, 32'h00100093, IMM_I, 1'b0);
        tick();
        chk("bp1_rdy", 64'(bus32.inReady), 64'd1);
        drv(1'b1, 32'h00200093, IMM_I, 1'b0);
        tick();
        chk("bp2_rdy", 64'(bus32.inReady), 64'd0);
        drv(1'b1, 32'h00300093, IMM_I, 1'b0);
        tick();
        chk("bp3_rdy", 64'(bus32.inReady), 64'd0);
        chk_out("bp3_head", 32'h1, IMM_I, 1'b0);
        drv(1'b1, 32'h00300093, IMM_I, 1'b1);
        tick();
        chk("bp4_rdy", 64'(bus32.inReady), 64'd1);
        chk_out("bp4_head", 32'h2, IMM_I, 1'b0);
        tick();
        chk_out("bp5_head", 32'h3, IMM_I, 1'b0);
        drv(1'b0, 32'h0, IMM_I, 1'b1);
        tick();
        chk("bp6_vld", 64'(bus32.outValid), 64'd0);
        chk("bp6_imm", 64'(bus32.immOut),   64'd3);

        // Flush with a simultaneous push and pop on a full buffer.
        drv(1'b1, 32'h00D00093, IMM_I, 1'b0);
        tick();
        drv(1'b1, 32'h00E00093, IMM_I, 1'b0);
        tick();
        drv(1'b1, 32'h00F00093, IMM_I, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drv(1'b0, 32'h0, IMM_I, 1'b1);
        chk("fl_vld", 64'(bus32.outValid), 64'd0);
        chk("fl_rdy", 64'(bus32.inReady),  64'd1);
        chk("fl_imm", 64'(bus32.immOut),   64'd3);
        tick();
        chk("fl2_vld", 64'(bus32.outValid), 64'd0);
        chk("fl2_imm", 64'(bus32.immOut),   64'd3);

        // Asynchronous reset mid-stream with the buffer full.
        drv(1'b1, 32'h00100093, IMM_I, 1'b0);
        tick();
        drv(1'b1, 32'h00200093, IMM_I, 1'b0);
        tick();
        chk("ar_full", 64'(bus32.inReady), 64'd0);
        #2;
        rstN = 1'b0;
        #1;
        chk("ar_vld", 64'(bus32.outValid), 64'd0);
        chk("ar_rdy", 64'(bus32.inReady),  64'd1);
        chk("ar_imm", 64'(bus32.immOut),   64'd0);
        drv(1'b0, 32'h0, IMM_I, 1'b0);
        tick();
        rstN = 1'b1;
        drv(1'b1, 32'h00500093, IMM_I, 1'b1);
        tick();
        chk_out("ar_post", 32'h5, IMM_I, 1'b0);
        drv(1'b0, 32'h0, IMM_I, 1'b1);
        tick();

        // 64-bit, single-entry instance: full on every push, pop never frees a slot same cycle.
        drv64(1'b1, 32'hFFF00093, IMM_I, 1'b0);
        tick();
        chk("d1_vld", 64'(bus64.outValid), 64'd1);
        chk("d1_rdy", 64'(bus64.inReady),  64'd0);
        chk("d1_imm", bus64.immOut,        64'hFFFFFFFF_FFFFFFFF);
        drv64(1'b1, 32'h80000037, IMM_U, 1'b1);
        tick();
        chk("d1_pop_vld", 64'(bus64.outValid), 64'd0);
        chk("d1_pop_rdy", 64'(bus64.inReady),  64'd1);
        chk("d1_hold",    bus64.immOut,        64'hFFFFFFFF_FFFFFFFF);
        tick();
        chk("d1_refill_vld", 64'(bus64.outValid), 64'd1);
        chk("d1_refill_imm", bus64.immOut,        64'hFFFFFFFF_80000000);
        drv64(1'b0, 32'h0, IMM_I, 1'b1);
        tick();
        for (int i = 0; i < NV; i++) begin
            drv64(1'b1, vecs[i].ins, vecs[i].sel, 1'b1);
            tick();
            chk($sformatf("x%0d_vld", i), 64'(bus64.outValid), 64'd1);
            chk($sformatf("x%0d_imm", i), bus64.immOut,        vecs[i].i64);
            chk($sformatf("x%0d_fmt", i), 64'(bus64.immFmt),   64'(vecs[i].fmt));
            chk($sformatf("x%0d_err", i), 64'(bus64.immErr),   64'(vecs[i].err));
            drv64(1'b0, 32'h0, IMM_I, 1'b1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the RISC-V decode stage. It supports all base formats (I, S, B, U, J, shift-amount), an opcode-driven auto-format mode, and XLEN 32 or 64. A valid/ready handshake on both sides and a small output buffer let it sit between fetch/decode and the register-read stage under backpressure.

Parameters:
XLEN, 32, output width; legal values 32 or 64.
DEPTH, 2, output buffer entries; legal values 1 to 4.
AUTO_EN, 1, 1 enables immSel=111 opcode auto-decode; 0 makes 111 a reserved code.

Ports:
clk  input  1  rising-edge clock
rstN  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered entries
inValid  input  1  instr/immSel are valid this cycle
inReady  output  1  block can accept an entry this cycle
instr  input  32  raw instruction word
immSel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 reserved, 111 AUTO
outValid  output  1  head entry is valid
outReady  input  1  consumer takes the head entry this cycle
immOut  output  XLEN  immediate of the head entry
immFmt  output  3  resolved format of the head entry (never 111)
immErr  output  1  head entry had a reserved select or an unknown opcode under AUTO

Behaviour:
- Reset (rstN low, asynchronous): buffer empty, outValid=0, inReady=1, immOut=0, immFmt=000, immErr=0. Deassertion takes effect on the next clk edge.
- Accept: inValid && inReady at an edge. Push: instr and format are decoded combinationally, then written to the buffer tail.
- Pop: outValid && outReady at an edge advances the head.
- Ordering: strict FIFO order is preserved.
- Latency: an entry accepted at edge N into an empty buffer is visible with outValid=1 from edge N onward, one cycle of latency. There is no combinational path from in to out.
- Ready: inReady = !full, computed from registered count only. outReady must not combinationally affect inReady. When full, a simultaneous pop does not enable a push that cycle.
- Simultaneous push and pop when neither empty nor full: count is unchanged and both operations complete.
- Empty buffer: immOut, immFmt and immErr hold the last popped values. They are don't-care to the consumer, but must not be X.
- Flush: at an edge with flush=1, count is set to 0 and outValid=0. Any push or pop that same cycle is discarded. inReady is unaffected, since it is registered from count.
- Sign extension:
  - I, S, B and J: bits above the format's top bit are replicated from instr[31] up to XLEN-1.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
- Format fields:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
- AUTO (AUTO_EN=1), decoded from opcode instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011 resolve to I.
  - 0100011 resolves to S.
  - 1100011 resolves to B.
  - 0110111, 0010111 resolve to U.
  - 1101111 resolves to J.
  - Any other opcode sets immErr=1.
- Error entries: immOut=0, immFmt=110, immErr=1. The entry is still buffered and delivered in order; there is never a Z output.
- Counters:
  - Head and tail pointers wrap modulo DEPTH.
  - count runs 0..DEPTH with a width of clog2(DEPTH+1).
  - DEPTH=1 must work, including full on every push and no same-cycle refill.

Decomposition:
- Package imm_pkg holds:
  - The IMM_SEL encodings as localparams: IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_RSVD, IMM_AUTO.
  - Opcode constants: OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
- One sub-module, imm_decode_comb, is natural. It is purely combinational: it takes instr and immSel and produces imm[XLEN-1:0], fmt and err.
- The top module holds the buffer, pointers, count and handshake logic.

Test Plan:
1. XLEN=32, push instr=0xFFF00093 with sel I, outReady=1. Required: one cycle later immOut=0xFFFFFFFF, immFmt=000, immErr=0. With XLEN=64, immOut=0xFFFFFFFFFFFFFFFF.
2. Push 0xFE112E23 (S), then 0xFE000CE3 (B), then 0x123450B7 (U), all with sel AUTO. Required, in order: 0xFFFFFFFC/001, 0xFFFFFFF8/010, 0x12345000/011.
3. DEPTH=2, outReady=0, attempt three pushes. Required: inReady drops after the 2nd accept and the 3rd is held. Raising outReady drains 1st then 2nd, and the 3rd is accepted the cycle after count<2.
4. Push sel=110 with any instr, and sel AUTO with instr=0x0000007F. Required: both deliver immOut=0, immFmt=110, immErr=1, in order with neighbouring good entries.
5. Buffer holds 2 entries; assert flush together with inValid=1 and outReady=1. Required: next cycle outValid=0, count=0, and neither the pushed nor the popped entry is observed.
6. Assert rstN low asynchronously mid-stream with the buffer full. Required: outValid=0 and inReady=1 immediately, without waiting for clk. After release, a push of 0x00500093 (I) yields 0x00000005.
